reg_writeback_queue: RTL and testbench
======================================

REG_WRITEBACK_QUEUE -- requirements
Module: reg_writeback_queue

Interface
REQ-001 The block SHALL have the parameter DEPTH, default 4, giving the number of pending-write entries (power of two, 2..8).
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-003 The block SHALL have the port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have the port in_valid, input, 1 bit: a producer write request is present.
REQ-005 The block SHALL have the port in_ready, output, 1 bit: the queue can accept a request this cycle.
REQ-006 The block SHALL have the ports in_reg (input, 4 bits) and in_data (input, 16 bits): the destination register index and write value.
REQ-007 The block SHALL have the port drain_stall, input, 1 bit: inhibits draining into the register file this cycle.
REQ-008 The block SHALL have the port wr_en, output, 1 bit: write strobe to the register-file write decoder.
REQ-009 The block SHALL have the ports wr_reg (output, 4 bits) and wr_data (output, 16 bits): the register-file write index and data.
REQ-010 The block SHALL have the ports rd_reg1 and rd_reg2, input, 4 bits each: the register-file read-port indices for bypass lookup.
REQ-011 The block SHALL have the ports byp_hit1 and byp_hit2 (output, 1 bit each) and byp_data1 and byp_data2 (output, 16 bits each): bypass results.
REQ-012 The block SHALL have the ports count (output, $clog2(DEPTH)+1 bits), empty (output, 1 bit) and full (output, 1 bit): occupancy.

Function
REQ-013 The block SHALL be a circular FIFO of {reg[3:0], data[15:0]} entries with head and tail pointers that wrap modulo DEPTH.
REQ-014 An enqueue SHALL occur when in_valid && in_ready && in_reg != 0; writes to R0 SHALL be accepted (handshake completes) and discarded.
REQ-015 in_ready SHALL equal !full, with no pass-through when full even if a drain occurs in the same cycle.
REQ-016 wr_en SHALL equal !empty && !drain_stall, with wr_reg/wr_data driven combinationally from the head entry; a dequeue SHALL occur exactly when wr_en is high.
REQ-017 Minimum latency SHALL be 1 cycle: a request accepted in cycle N appears on wr_en in cycle N+1 when the queue was empty and drain_stall is low.
REQ-018 A simultaneous enqueue and dequeue SHALL leave count unchanged and move both pointers.
REQ-019 count SHALL equal the number of valid entries, with empty = (count==0) and full = (count==DEPTH).
REQ-020 When empty, wr_reg and wr_data SHALL be 0.
REQ-021 byp_hitK SHALL be 1 when any valid entry, including the head being drained this cycle, has reg == rd_regK != 0.
REQ-022 byp_dataK SHALL be the data of the youngest matching entry, and 0 when there is no hit.
REQ-023 A request being enqueued in the same cycle SHALL NOT be visible to bypass until the next cycle.
REQ-024 Multiple pending writes to the same register SHALL drain in arrival order, with no coalescing.

Reset
REQ-025 While rst is high at a clock edge, pointers and count SHALL be cleared to 0 and all entries invalidated; in-flight requests SHALL be dropped.
REQ-026 After reset, and while rst is high, the outputs SHALL be: in_ready=1, empty=1, full=0, count=0, wr_en=0, wr_reg=0, wr_data=0, byp_hit*=0, byp_data*=0.
REQ-027 Entry data storage SHALL NOT require reset; only the valid/pointer state resets.

Configuration
REQ-028 With macro WB_BYPASS_EN defined, the bypass logic SHALL be built as in REQ-021..023.
REQ-029 With WB_BYPASS_EN undefined, byp_hit* and byp_data* SHALL be tied to 0 and no comparators SHALL be built; the ports SHALL remain present.

Structure
REQ-030 A shared package SHALL hold the REG_IDX_W=4 and DATA_W=16 constants and the wbq_entry_t typedef {reg, data}.
REQ-031 One sub-module, wbq_bypass_match, SHALL implement the youngest-match priority search and be instantiated once per read port.

Verification
REQ-032 Reset then idle: empty=1, in_ready=1, wr_en=0, count=0.
REQ-033 Enqueue R3=0x1234 in cycle N: wr_en=1, wr_reg=3, wr_data=0x1234 in cycle N+1, then empty.
REQ-034 With drain_stall=1, enqueue 4 writes: full=1 and in_ready=0; a 5th request is held; releasing the stall drains the entries in order, one per cycle.
REQ-035 Under stall, queue R5=0x0001 then R5=0x0002 with rd_reg1=5: byp_hit1=1 and byp_data1=0x0002; rd_reg2=0 gives byp_hit2=0.
REQ-036 Enqueue to R0 with in_valid=1: in_ready=1, count stays 0, and no wr_en follows.
REQ-037 Fill 2 entries, assert rst for 1 cycle mid-drain: next cycle count=0, wr_en=0, byp_hit*=0; repeat with WB_BYPASS_EN undefined and check byp_* stays 0.

Source files
------------

// File: rtl/reg_writeback_queue_pkg.sv
// -----------------------------------------------------------------------------
// reg_writeback_queue_pkg
//   Shared constants and the queue entry type for the register write-back
//   queue and its bypass matcher.
//
//   REG_IDX_W   : width of a register-file index
//   DATA_W      : width of a register value
//   wbq_entry_t : one pending write, {reg_idx, data}
// -----------------------------------------------------------------------------
package reg_writeback_queue_pkg;

    localparam int REG_IDX_W = 4;
    localparam int DATA_W    = 16;

    typedef struct packed {
        logic [REG_IDX_W-1:0] reg_idx;
        logic [DATA_W-1:0]    data;
    } wbq_entry_t;

endpackage

// File: rtl/reg_writeback_queue_bypass_match.sv
// -----------------------------------------------------------------------------
// wbq_bypass_match
//   Youngest-match search over the valid entries of the write-back queue for
//   one register-file read port.
//
//   Parameters : DEPTH      number of queue entries (power of two)
//   Inputs     : entries_i  queue storage, indexed by physical slot
//                head_i     slot of the oldest valid entry
//                count_i    number of valid entries
//                rd_reg_i   read-port register index (R0 never matches)
//   Outputs    : hit_o      some valid entry targets rd_reg_i
//                data_o     data of the youngest such entry, 0 on no hit
// -----------------------------------------------------------------------------
module wbq_bypass_match
    import reg_writeback_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wbq_entry_t [DEPTH-1:0]     entries_i,
    input  logic [$clog2(DEPTH)-1:0]   head_i,
    input  logic [$clog2(DEPTH):0]     count_i,
    input  logic [REG_IDX_W-1:0]       rd_reg_i,
    output logic                       hit_o,
    output logic [DATA_W-1:0]          data_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Walk from oldest to youngest; a later match overwrites an earlier one,
    // so the youngest matching entry wins.
    // NOTE: every output gets a default before the loop, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((CNT_W'(k) < count_i) && (rd_reg_i != '0) &&
                (entries_i[head_i + PTR_W'(k)].reg_idx == rd_reg_i)) begin
                hit_o  = 1'b1;
                data_o = entries_i[head_i + PTR_W'(k)].data;
            end
        end
    end

endmodule

// File: rtl/reg_writeback_queue.sv
// -----------------------------------------------------------------------------
// reg_writeback_queue
//   Circular FIFO of pending register-file writes. Producers enqueue
//   {reg, data}; the head drains into the register-file write port one per
//   cycle unless drain_stall is high. Writes to R0 are accepted and dropped.
//   Optional bypass lookup for two read ports is built only when the macro
//   WB_BYPASS_EN is defined; otherwise the bypass outputs are tied to 0.
//
//   Parameters : DEPTH (power of two, 2..8)
//   Clock/reset: clk, rst (synchronous, active-high)
//   Producer   : in_valid, in_ready, in_reg[3:0], in_data[15:0]
//   Drain      : drain_stall, wr_en, wr_reg[3:0], wr_data[15:0]
//   Bypass     : rd_reg1/2[3:0], byp_hit1/2, byp_data1/2[15:0]
//   Occupancy  : count, empty, full
// -----------------------------------------------------------------------------
module reg_writeback_queue
    import reg_writeback_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [REG_IDX_W-1:0]     in_reg,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     drain_stall,
    output logic                     wr_en,
    output logic [REG_IDX_W-1:0]     wr_reg,
    output logic [DATA_W-1:0]        wr_data,
    input  logic [REG_IDX_W-1:0]     rd_reg1,
    input  logic [REG_IDX_W-1:0]     rd_reg2,
    output logic                     byp_hit1,
    output logic                     byp_hit2,
    output logic [DATA_W-1:0]        byp_data1,
    output logic [DATA_W-1:0]        byp_data2,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]       head_q, head_d;
    logic [PTR_W-1:0]       tail_q, tail_d;
    logic [CNT_W-1:0]       count_q, count_d;
    wbq_entry_t [DEPTH-1:0] mem_q;

    logic       push;
    logic       pop;
    wbq_entry_t head_entry;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign count    = count_q;

    // Acceptance depends only on the registered occupancy: a full queue does
    // not take a new request even if the head drains in the same cycle.
    assign in_ready = !full;
    assign push     = in_valid && in_ready && (in_reg != '0);
    assign pop      = !empty && !drain_stall;

    assign head_entry = mem_q[head_q];
    assign wr_en      = pop;
    assign wr_reg     = empty ? '0 : head_entry.reg_idx;
    assign wr_data    = empty ? '0 : head_entry.data;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) begin
            tail_d = tail_q + PTR_W'(1);
        end
        if (pop) begin
            head_d = head_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: registered state is written with non-blocking assignments so every
    // flop samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: entry storage has no reset; validity is defined entirely by
    // head/count, so clearing those invalidates every slot.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q] <= '{reg_idx: in_reg, data: in_data};
        end
    end

`ifdef WB_BYPASS_EN
    // Lookup uses registered state only, so a request being enqueued this
    // cycle becomes visible next cycle, while the head being drained this
    // cycle is still visible.
    wbq_bypass_match #(.DEPTH(DEPTH)) u_byp1 (
        .entries_i (mem_q),
        .head_i    (head_q),
        .count_i   (count_q),
        .rd_reg_i  (rd_reg1),
        .hit_o     (byp_hit1),
        .data_o    (byp_data1)
    );

    wbq_bypass_match #(.DEPTH(DEPTH)) u_byp2 (
        .entries_i (mem_q),
        .head_i    (head_q),
        .count_i   (count_q),
        .rd_reg_i  (rd_reg2),
        .hit_o     (byp_hit2),
        .data_o    (byp_data2)
    );
`else
    logic unused_rd_regs;
    assign unused_rd_regs = ^{rd_reg1, rd_reg2};

    assign byp_hit1  = 1'b0;
    assign byp_hit2  = 1'b0;
    assign byp_data1 = '0;
    assign byp_data2 = '0;
`endif

endmodule

// File: tb/tb_reg_writeback_queue.sv
// -----------------------------------------------------------------------------
// tb_reg_writeback_queue
//   Directed self-checking bench for reg_writeback_queue (DEPTH = 4).
//   Bypass expectations follow the WB_BYPASS_EN macro of the build.
// -----------------------------------------------------------------------------
module tb_reg_writeback_queue;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_reg;
    logic [15:0] in_data;
    logic        drain_stall;
    logic        wr_en;
    logic [3:0]  wr_reg;
    logic [15:0] wr_data;
    logic [3:0]  rd_reg1;
    logic [3:0]  rd_reg2;
    logic        byp_hit1;
    logic        byp_hit2;
    logic [15:0] byp_data1;
    logic [15:0] byp_data2;
    logic [2:0]  count;
    logic        empty;
    logic        full;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    reg_writeback_queue #(.DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_reg      (in_reg),
        .in_data     (in_data),
        .drain_stall (drain_stall),
        .wr_en       (wr_en),
        .wr_reg      (wr_reg),
        .wr_data     (wr_data),
        .rd_reg1     (rd_reg1),
        .rd_reg2     (rd_reg2),
        .byp_hit1    (byp_hit1),
        .byp_hit2    (byp_hit2),
        .byp_data1   (byp_data1),
        .byp_data2   (byp_data2),
        .count       (count),
        .empty       (empty),
        .full        (full)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle 1 time unit past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0]  exp_reg  [4];
    logic [15:0] exp_data [4];

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_reg = '0; in_data = '0;
        drain_stall = 1'b0; rd_reg1 = '0; rd_reg2 = '0;

        // Outputs while reset is held.
        tick(); tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_empty",    32'(empty),    32'd1);
        check("rst_full",     32'(full),     32'd0);
        check("rst_count",    32'(count),    32'd0);
        check("rst_wr_en",    32'(wr_en),    32'd0);
        check("rst_wr_reg",   32'(wr_reg),   32'd0);
        check("rst_wr_data",  32'(wr_data),  32'd0);
        check("rst_byp_hit1", 32'(byp_hit1), 32'd0);
        check("rst_byp_hit2", 32'(byp_hit2), 32'd0);
        check("rst_byp_d1",   32'(byp_data1), 32'd0);
        check("rst_byp_d2",   32'(byp_data2), 32'd0);

        // Idle after reset.
        rst = 1'b0;
        tick();
        check("idle_empty",    32'(empty),    32'd1);
        check("idle_in_ready", 32'(in_ready), 32'd1);
        check("idle_wr_en",    32'(wr_en),    32'd0);
        check("idle_count",    32'(count),    32'd0);

        // Single write R3 = 0x1234, one-cycle latency.
        in_valid = 1'b1; in_reg = 4'd3; in_data = 16'h1234;
        #1 check("lat_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        #1;
        check("lat_wr_en",   32'(wr_en),   32'd1);
        check("lat_wr_reg",  32'(wr_reg),  32'd3);
        check("lat_wr_data", 32'(wr_data), 32'h1234);
        check("lat_count",   32'(count),   32'd1);
        tick();
        check("lat_empty",   32'(empty),   32'd1);
        check("lat_wr_en0",  32'(wr_en),   32'd0);
        check("lat_wr_reg0", 32'(wr_reg),  32'd0);
        check("lat_wr_dat0", 32'(wr_data), 32'd0);

        // Fill under stall, hold a 5th request, then drain in order.
        drain_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_reg = 4'(i + 1); in_data = 16'hA001 + 16'(i);
            tick();
        end
        in_reg = 4'd6; in_data = 16'hA006;
        #1;
        check("fill_full",     32'(full),     32'd1);
        check("fill_in_ready", 32'(in_ready), 32'd0);
        check("fill_count",    32'(count),    32'd4);
        check("fill_wr_en",    32'(wr_en),    32'd0);
        check("fill_head_reg", 32'(wr_reg),   32'd1);
        rd_reg1 = 4'd2;
        #1 check("fill_byp_d1", 32'(byp_data1), BYP ? 32'hA002 : 32'h0);
        rd_reg1 = '0;
        tick();
        check("held_count",    32'(count),    32'd4);
        drain_stall = 1'b0;
        #1;
        check("full_no_pass",  32'(in_ready), 32'd0);
        check("drain0_wr_en",  32'(wr_en),    32'd1);
        check("drain0_reg",    32'(wr_reg),   32'd1);
        check("drain0_data",   32'(wr_data),  32'hA001);
        tick();
        check("drain1_ready",  32'(in_ready), 32'd1);
        check("drain1_count",  32'(count),    32'd3);
        check("drain1_reg",    32'(wr_reg),   32'd2);
        tick();
        in_valid = 1'b0;
        check("pushpop_count", 32'(count),    32'd3);
        exp_reg[0] = 4'd3; exp_data[0] = 16'hA003;
        exp_reg[1] = 4'd4; exp_data[1] = 16'hA004;
        exp_reg[2] = 4'd6; exp_data[2] = 16'hA006;
        for (int i = 0; i < 3; i++) begin
            check("order_wr_en", 32'(wr_en),   32'd1);
            check("order_reg",   32'(wr_reg),  32'(exp_reg[i]));
            check("order_data",  32'(wr_data), 32'(exp_data[i]));
            tick();
        end
        check("order_empty", 32'(empty), 32'd1);

        // Two writes to R5 under stall: youngest wins, same-cycle enqueue hidden.
        drain_stall = 1'b1; rd_reg1 = 4'd5; rd_reg2 = 4'd0;
        in_valid = 1'b1; in_reg = 4'd5; in_data = 16'h0001;
        tick();
        in_data = 16'h0002;
        #1 check("byp_hidden_d1", 32'(byp_data1), BYP ? 32'h1 : 32'h0);
        tick();
        in_valid = 1'b0;
        #1;
        check("byp_hit1",  32'(byp_hit1),  BYP ? 32'd1 : 32'd0);
        check("byp_data1", 32'(byp_data1), BYP ? 32'h2 : 32'h0);
        check("byp_hit2",  32'(byp_hit2),  32'd0);
        check("byp_data2", 32'(byp_data2), 32'd0);
        drain_stall = 1'b0;
        #1;
        check("r5_first",      32'(wr_data),   32'h1);
        check("byp_drain_d1",  32'(byp_data1), BYP ? 32'h2 : 32'h0);
        tick();
        check("r5_second",     32'(wr_data),   32'h2);
        check("byp_head_hit",  32'(byp_hit1),  BYP ? 32'd1 : 32'd0);
        tick();
        check("byp_gone_hit",  32'(byp_hit1),  32'd0);
        rd_reg1 = '0;

        // Write to R0: handshake completes, nothing stored.
        in_valid = 1'b1; in_reg = 4'd0; in_data = 16'hBEEF;
        #1 check("r0_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        #1;
        check("r0_count", 32'(count), 32'd0);
        check("r0_wr_en", 32'(wr_en), 32'd0);
        check("r0_empty", 32'(empty), 32'd1);

        // Reset mid-drain with an in-flight request.
        drain_stall = 1'b1;
        in_valid = 1'b1; in_reg = 4'd7; in_data = 16'h0007;
        tick();
        in_reg = 4'd8; in_data = 16'h0008;
        tick();
        in_valid = 1'b0; drain_stall = 1'b0; rd_reg1 = 4'd8; rd_reg2 = 4'd7;
        #1 check("mid_wr_reg", 32'(wr_reg), 32'd7);
        tick();
        check("mid_count",  32'(count),    32'd1);
        check("mid_byp_h1", 32'(byp_hit1), BYP ? 32'd1 : 32'd0);
        rst = 1'b1; in_valid = 1'b1; in_reg = 4'd9; in_data = 16'h0009;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        #1;
        check("rst2_count",  32'(count),     32'd0);
        check("rst2_wr_en",  32'(wr_en),     32'd0);
        check("rst2_byp_h1", 32'(byp_hit1),  32'd0);
        check("rst2_byp_h2", 32'(byp_hit2),  32'd0);
        check("rst2_byp_d1", 32'(byp_data1), 32'd0);
        check("rst2_empty",  32'(empty),     32'd1);
        tick();
        check("rst2_idle_wr_en", 32'(wr_en), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
